bin_sequencer: RTL and testbench
================================

# bin_sequencer

Run controller for the `binarization` datapath. On a single start request it issues the init pulse, waits for the datapath to sweep the whole frame, issues the binarization pulse, and waits for the second sweep. Completion is detected from the datapath's `pixel_address`, not from fixed delays. The block latches and holds the threshold for the whole run, and reports status to board LEDs and the top level.

## Interface

**Parameters**
- `PULSE_LEN`, default 10: cycles that `int_ctrl` and `bin_ctrl` are held high; must be ≥1.
- `IMG_PIXELS`, default 65536: pixels per frame. The last address is `IMG_PIXELS-1`.
- `ADDR_W`, default 16: width of `pixel_address`.
- `TIMEOUT`, default 70000: maximum cycles allowed per wait phase before error.

**Ports**
- `bin_clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: run request, level-sampled, acted on only when not busy.
- `abort`, in, 1: cancels a run in progress.
- `skip_init`, in, 1: when high at start, the init phase is skipped.
- `thres_in`, in, 8: threshold source, sampled at start.
- `pixel_address`, in, ADDR_W: address currently driven by the datapath.
- `int_ctrl`, out, 1: init pulse to the datapath.
- `bin_ctrl`, out, 1: binarize pulse to the datapath.
- `thres_length`, out, 8: latched threshold to the datapath.
- `busy`, out, 1: high in every state except IDLE, DONE and ERROR.
- `done`, out, 1: one-cycle pulse on entry to DONE.
- `error`, out, 1: high while in ERROR.
- `state_led`, out, 2: status code: 00 idle, 01 init phase, 10 bin phase, 11 done or error.

## Operation

**States:** IDLE, INIT_PULSE, INIT_WAIT, BIN_PULSE, BIN_WAIT, DONE, ERROR.

**Start**
- Accepted in IDLE, DONE or ERROR when `start`=1 at an edge.
- Latches `thres_in` into `thres_length`.
- Clears `error`.
- Goes to INIT_PULSE, or to BIN_PULSE if `skip_init`=1.

**Pulse states**
- `int_ctrl`/`bin_ctrl` is high for exactly `PULSE_LEN` cycles, counted by a pulse counter.
- Then the FSM moves to the matching WAIT state.
- The wait logic is cleared on entry to every WAIT state: armed=0, wait counter=0.

**Wait states**
- An `armed` flag sets on the first sample with `pixel_address != IMG_PIXELS-1`.
- Completion is a sample with `armed`=1 and `pixel_address == IMG_PIXELS-1`.
- INIT_WAIT completion goes to BIN_PULSE; BIN_WAIT completion goes to DONE.
- The wait counter increments every cycle in a WAIT state. If it reaches `TIMEOUT` without completion, the FSM goes to ERROR.
- If completion and timeout occur on the same cycle, completion wins.

**Abort**
- `abort`=1 in any busy state goes to IDLE at the next edge and drops both pulses in that same cycle.
- `abort` is ignored when not busy.
- If `abort` and `start` are both high when not busy, `start` is honoured.

**Other rules**
- `start` while busy is ignored; it is not queued.
- `thres_length` holds its value after DONE, ERROR and abort; only reset or a new start changes it.
- All counters are unsigned with no wrap. The wait counter is wide enough for `TIMEOUT`; the pulse counter is wide enough for `PULSE_LEN`.

## Timing

- All outputs are registered.
- Reset values: state IDLE, `int_ctrl`=0, `bin_ctrl`=0, `thres_length`=0, `busy`=0, `done`=0, `error`=0, `state_led`=00.
- Reset asserted mid-run returns every output to its reset value at the next edge.
- `start` sampled at edge k: `int_ctrl`=1, `busy`=1 and the new `thres_length` are all visible after edge k. `int_ctrl` falls after edge k+`PULSE_LEN`.
- A pulse state is followed immediately by its WAIT state, with no gap cycle.
- `pixel_address` sampled equal to the last address at edge m (with `armed`=1):
  - from INIT_WAIT, `bin_ctrl` rises after edge m;
  - from BIN_WAIT, `done`=1 and `busy`=0 after edge m, and `done` clears after edge m+1.
- Timeout: ERROR is entered at the edge where the wait counter equals `TIMEOUT`; `error` is visible after that edge.

## Structure

- Package `bin_seq_pkg` holds:
  - the state enum;
  - the `state_led` code constants;
  - the default `IMG_PIXELS` and `TIMEOUT` constants.
- One sub-module, `bin_phase_watch`, contains the armed flag, the wait counter and the completion/timeout compare. It is reused by both WAIT states and cleared on WAIT-state entry.

## Test plan

- **Nominal run:** behavioural datapath model counts `pixel_address` 0→65535 after each pulse; `thres_in`=80, `start` for 1 cycle. Required: `int_ctrl` high for 10 cycles; `bin_ctrl` high for 10 cycles after the first sweep; `done` pulses once; `thres_length`=80 throughout.
- **skip_init:** `start` with `skip_init`=1. Required: `int_ctrl` never rises, `bin_ctrl` rises one cycle after `start`, `state_led`=10.
- **Timeout:** model stalls `pixel_address` at 100 during BIN_WAIT. Required: `error`=1 exactly 70000 cycles after BIN_WAIT entry, `state_led`=11; a new `start` clears `error`.
- **Stale address:** `pixel_address` held at 65535 on WAIT entry. Required: no completion until the address leaves 65535 and returns.
- **Abort and busy start:** `abort` during INIT_WAIT. Required: IDLE, pulses low, `thres_length` retained. `start` while busy: no effect. `start`+`abort` together in IDLE: run starts.
- **Reset mid-run:** `rst_n`=0 for 1 cycle during BIN_PULSE. Required: all outputs at reset values after the next edge.

Source files
------------

// File: rtl/bin_seq_pkg.sv
// Shared definitions for the bin_sequencer run controller.
// Holds the FSM state enum, the state_led status codes, the default frame and
// timeout sizes, and small helpers that decode a state into busy / LED code.
package bin_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInitPulse,
        StInitWait,
        StBinPulse,
        StBinWait,
        StDone,
        StError
    } state_e;

    localparam logic [1:0] LedIdle = 2'b00;
    localparam logic [1:0] LedInit = 2'b01;
    localparam logic [1:0] LedBin  = 2'b10;
    localparam logic [1:0] LedEnd  = 2'b11;

    localparam int unsigned DefImgPixels = 65536;
    localparam int unsigned DefTimeout   = 70000;

    function automatic logic is_busy(state_e s);
        return s inside {StInitPulse, StInitWait, StBinPulse, StBinWait};
    endfunction

    function automatic logic [1:0] led_code(state_e s);
        case (s)
            StInitPulse, StInitWait: return LedInit;
            StBinPulse, StBinWait:   return LedBin;
            StDone, StError:         return LedEnd;
            default:                 return LedIdle;
        endcase
    endfunction

endpackage

// File: rtl/bin_seq_if.sv
// Datapath-side bundle between bin_sequencer and the binarization datapath.
//   pixel_address : address the datapath is currently driving
//   int_ctrl      : init pulse to the datapath
//   bin_ctrl      : binarize pulse to the datapath
//   thres_length  : threshold held for the whole run
// master = sequencer side, slave = datapath side.
interface bin_seq_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] pixel_address;
    logic              int_ctrl;
    logic              bin_ctrl;
    logic [7:0]        thres_length;

    modport master (
        input  pixel_address,
        output int_ctrl,
        output bin_ctrl,
        output thres_length
    );

    modport slave (
        output pixel_address,
        input  int_ctrl,
        input  bin_ctrl,
        input  thres_length
    );
endinterface

// File: rtl/bin_phase_watch.sv
// Sweep-completion watcher shared by both WAIT states.
//   bin_clk, rst_n : clock, synchronous active-low reset
//   clear          : pulse on WAIT-state entry; zeroes armed flag and counter
//   active         : high while the FSM sits in a WAIT state
//   pixel_address  : datapath address
//   complete       : armed and the last address is seen this cycle
//   timeout        : the wait counter reaches TIMEOUT at the next edge
module bin_phase_watch
    import bin_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned IMG_PIXELS = DefImgPixels,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic              bin_clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              active,
    input  logic [ADDR_W-1:0] pixel_address,
    output logic              complete,
    output logic              timeout
);
    localparam int unsigned       CntW     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMG_PIXELS - 1);

    logic            armed_q, armed_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_last;

    always_comb begin
        at_last = (pixel_address == LastAddr);
        armed_d = armed_q;
        cnt_d   = cnt_q;
        if (clear) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (active) begin
            // A stale last address at entry must not count as completion.
            if (!at_last) armed_d = 1'b1;
            if (cnt_q != CntW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        end
        complete = active && armed_q && at_last;
        // Fires on the edge where the counter would become TIMEOUT.
        timeout  = active && (cnt_q == CntW'(TIMEOUT - 1));
    end

    always_ff @(posedge bin_clk) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/bin_sequencer.sv
// Run controller for the binarization datapath: init pulse, wait for sweep,
// binarize pulse, wait for sweep, then DONE (or ERROR on timeout).
//   bin_clk, rst_n : clock, synchronous active-low reset
//   start, abort   : run request / cancel (level-sampled)
//   skip_init      : at start, go straight to the binarize pulse
//   thres_in       : threshold source, latched at start
//   dp             : datapath bundle (pixel_address in; pulses, threshold out)
//   busy, done, error, state_led : registered status
module bin_sequencer
    import bin_seq_pkg::*;
#(
    parameter int unsigned PULSE_LEN  = 10,
    parameter int unsigned IMG_PIXELS = DefImgPixels,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic       bin_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       skip_init,
    input  logic [7:0] thres_in,
    bin_seq_if.master  dp,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] state_led
);
    localparam int unsigned PW = $clog2(PULSE_LEN + 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [7:0]      thres_q, thres_d;
    logic            int_q, bin_q, busy_q, done_q, error_q;
    logic [1:0]      led_q;
    logic            watch_clear, watch_active, complete, timeout;

    bin_phase_watch #(
        .ADDR_W    (ADDR_W),
        .IMG_PIXELS(IMG_PIXELS),
        .TIMEOUT   (TIMEOUT)
    ) u_watch (
        .bin_clk      (bin_clk),
        .rst_n        (rst_n),
        .clear        (watch_clear),
        .active       (watch_active),
        .pixel_address(dp.pixel_address),
        .complete     (complete),
        .timeout      (timeout)
    );

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        thres_d = thres_q;

        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = skip_init ? StBinPulse : StInitPulse;
                    thres_d = thres_in;
                end
            end
            StInitPulse: if (pcnt_q == PW'(PULSE_LEN)) state_d = StInitWait;
            StBinPulse:  if (pcnt_q == PW'(PULSE_LEN)) state_d = StBinWait;
            StInitWait: begin
                if (complete)     state_d = StBinPulse;
                else if (timeout) state_d = StError;
            end
            StBinWait: begin
                if (complete)     state_d = StDone;
                else if (timeout) state_d = StError;
            end
            default: state_d = StIdle;
        endcase

        if (is_busy(state_q) && abort) state_d = StIdle;

        // Pulse counter starts at 1 on entry so the pulse lasts PULSE_LEN cycles.
        if (state_d == StInitPulse || state_d == StBinPulse) begin
            if (state_d != state_q)               pcnt_d = PW'(1);
            else if (pcnt_q != PW'(PULSE_LEN))    pcnt_d = pcnt_q + 1'b1;
        end

        watch_active = (state_q == StInitWait) || (state_q == StBinWait);
        watch_clear  = ((state_d == StInitWait) || (state_d == StBinWait)) &&
                       (state_d != state_q);
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge bin_clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pcnt_q  <= '0;
            thres_q <= '0;
            int_q   <= 1'b0;
            bin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            led_q   <= LedIdle;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            thres_q <= thres_d;
            int_q   <= (state_d == StInitPulse);
            bin_q   <= (state_d == StBinPulse);
            busy_q  <= is_busy(state_d);
            done_q  <= (state_d == StDone) && (state_q != StDone);
            error_q <= (state_d == StError);
            led_q   <= led_code(state_d);
        end
    end

    assign dp.int_ctrl     = int_q;
    assign dp.bin_ctrl     = bin_q;
    assign dp.thres_length = thres_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign state_led       = led_q;
endmodule

// File: tb/tb_bin_sequencer.sv
module tb_bin_sequencer;
    import bin_seq_pkg::*;

    localparam int unsigned PULSE_LEN  = 10;
    localparam int unsigned IMG_PIXELS = 64;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned TIMEOUT    = 300;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_PIXELS - 1);

    typedef struct packed {
        logic       is_err;
        logic [7:0] thres;
    } exp_t;

    logic clk, rst_n, start, abort, skip_init;
    logic [7:0] thres_in;
    logic busy, done, error;
    logic [1:0] state_led;

    logic model_en;
    logic [ADDR_W-1:0] model_addr, manual_addr;
    logic sweeping, dp_prev;
    int unsigned stall_at;

    int unsigned int_hi, bin_hi, done_cyc, ev_cnt;
    logic ev_err, done_p, err_p;
    logic [7:0] ev_thres;

    int n_checks, n_err;
    exp_t exp_q[$];

    bin_seq_if #(.ADDR_W(ADDR_W)) dpi ();
    assign dpi.pixel_address = model_en ? model_addr : manual_addr;

    bin_sequencer #(
        .PULSE_LEN (PULSE_LEN),
        .IMG_PIXELS(IMG_PIXELS),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .bin_clk  (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .skip_init(skip_init),
        .thres_in (thres_in),
        .dp       (dpi),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .state_led(state_led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural datapath: sweeps 0..LAST after each pulse falls, optional stall.
    initial begin
        model_addr = '0;
        sweeping   = 1'b0;
        dp_prev    = 1'b0;
        forever begin
            @(posedge clk);
            dp_prev <= dpi.int_ctrl | dpi.bin_ctrl;
            if (dp_prev && !(dpi.int_ctrl | dpi.bin_ctrl)) begin
                model_addr <= '0;
                sweeping   <= 1'b1;
            end else if (sweeping) begin
                if (32'(model_addr) == stall_at) begin
                    model_addr <= model_addr;
                end else if (model_addr == LAST) begin
                    sweeping <= 1'b0;
                end else begin
                    model_addr <= model_addr + 1'b1;
                end
            end
        end
    end

    // Output monitor: pulse-length counters and done/error event capture.
    initial begin
        int_hi = 0; bin_hi = 0; done_cyc = 0; ev_cnt = 0;
        ev_err = 1'b0; ev_thres = '0; done_p = 1'b0; err_p = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dpi.int_ctrl) int_hi++;
            if (dpi.bin_ctrl) bin_hi++;
            if (done) done_cyc++;
            if ((done && !done_p) || (error && !err_p)) begin
                ev_cnt++;
                ev_err   = error;
                ev_thres = dpi.thres_length;
            end
            done_p = done;
            err_p  = error;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] th, input logic skip);
        thres_in  = th;
        skip_init = skip;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        skip_init = 1'b0;
    endtask

    task automatic wait_low(input string tag, input logic use_bin, input int bound);
        int n = 0;
        while ((use_bin ? dpi.bin_ctrl : dpi.int_ctrl) && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(use_bin ? dpi.bin_ctrl : dpi.int_ctrl), 0);
    endtask

    task automatic wait_ev(input string tag, input int unsigned base, input int bound);
        int n = 0;
        exp_t e;
        while (ev_cnt == base && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(ev_cnt != base), 1);
        check({tag, "_sb_avail"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_kind"}, 32'(ev_err), 32'(e.is_err));
            check({tag, "_thres"}, 32'(ev_thres), 32'(e.thres));
        end
    endtask

    initial begin
        int unsigned i0, b0, d0, e0;
        int n;
        logic bad;
        n_checks = 0; n_err = 0;
        start = 0; abort = 0; skip_init = 0; thres_in = 8'h00;
        model_en = 1'b1; stall_at = 32'hFFFF_FFFF; manual_addr = LAST;
        rst_n = 1'b0;
        tick(); tick();
        check("rst_int",  32'(dpi.int_ctrl), 0);
        check("rst_bin",  32'(dpi.bin_ctrl), 0);
        check("rst_thres", 32'(dpi.thres_length), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_led",  32'(state_led), 32'(LedIdle));
        rst_n = 1'b1;
        tick();

        // Nominal run
        i0 = int_hi; b0 = bin_hi; d0 = done_cyc; e0 = ev_cnt;
        exp_q.push_back('{is_err: 1'b0, thres: 8'd80});
        do_start(8'd80, 1'b0);
        check("nom_int_rise", 32'(dpi.int_ctrl), 1);
        check("nom_busy", 32'(busy), 1);
        check("nom_thres", 32'(dpi.thres_length), 80);
        check("nom_led_init", 32'(state_led), 32'(LedInit));
        wait_ev("nom", e0, 2000);
        check("nom_done_hi", 32'(done), 1);
        check("nom_busy_lo", 32'(busy), 0);
        check("nom_int_len", int_hi - i0, PULSE_LEN);
        check("nom_bin_len", bin_hi - b0, PULSE_LEN);
        tick();
        check("nom_done_clr", 32'(done), 0);
        check("nom_done_once", done_cyc - d0, 1);
        check("nom_led_end", 32'(state_led), 32'(LedEnd));
        check("nom_thres_hold", 32'(dpi.thres_length), 80);

        // skip_init
        i0 = int_hi; b0 = bin_hi; e0 = ev_cnt;
        exp_q.push_back('{is_err: 1'b0, thres: 8'h5A});
        do_start(8'h5A, 1'b1);
        check("skip_int_lo", 32'(dpi.int_ctrl), 0);
        check("skip_bin_hi", 32'(dpi.bin_ctrl), 1);
        check("skip_led", 32'(state_led), 32'(LedBin));
        wait_ev("skip", e0, 2000);
        check("skip_no_int", int_hi - i0, 0);
        check("skip_bin_len", bin_hi - b0, PULSE_LEN);

        // Timeout in BIN_WAIT
        stall_at = 20;
        e0 = ev_cnt;
        exp_q.push_back('{is_err: 1'b1, thres: 8'h11});
        do_start(8'h11, 1'b1);
        wait_low("to_bin_fall", 1'b1, 50);
        check("to_in_wait", 32'(busy), 1);
        n = 0;
        while (!error && n < int'(TIMEOUT) + 20) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), TIMEOUT);
        check("to_led", 32'(state_led), 32'(LedEnd));
        check("to_busy", 32'(busy), 0);
        wait_ev("to", e0, 5);
        stall_at = 32'hFFFF_FFFF;
        e0 = ev_cnt;
        exp_q.push_back('{is_err: 1'b0, thres: 8'h22});
        do_start(8'h22, 1'b1);
        check("to_err_clr", 32'(error), 0);
        check("to_restart_busy", 32'(busy), 1);
        wait_ev("to_rerun", e0, 2000);

        // Stale last address on WAIT entry
        model_en = 1'b0;
        manual_addr = LAST;
        e0 = ev_cnt;
        exp_q.push_back('{is_err: 1'b0, thres: 8'h77});
        do_start(8'h77, 1'b1);
        wait_low("st_bin_fall", 1'b1, 50);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || !busy) bad = 1'b1;
        end
        check("st_no_early", 32'(bad), 0);
        manual_addr = 5;
        tick();
        check("st_away_busy", 32'(busy), 1);
        manual_addr = LAST;
        tick();
        check("st_done", 32'(done), 1);
        check("st_busy_lo", 32'(busy), 0);
        wait_ev("st", e0, 2);
        tick();
        check("st_done_clr", 32'(done), 0);

        // Abort during INIT_WAIT
        do_start(8'h33, 1'b0);
        wait_low("ab_int_fall", 1'b0, 50);
        check("ab_led_init", 32'(state_led), 32'(LedInit));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_led", 32'(state_led), 32'(LedIdle));
        check("ab_int", 32'(dpi.int_ctrl), 0);
        check("ab_bin", 32'(dpi.bin_ctrl), 0);
        check("ab_thres", 32'(dpi.thres_length), 32'h33);

        // Start while busy is ignored
        i0 = int_hi;
        do_start(8'h44, 1'b0);
        tick(); tick(); tick();
        do_start(8'h55, 1'b0);
        check("bs_thres", 32'(dpi.thres_length), 32'h44);
        wait_low("bs_int_fall", 1'b0, 50);
        check("bs_int_len", int_hi - i0, PULSE_LEN);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("bs_abort", 32'(busy), 0);

        // Start and abort together while idle: start wins
        thres_in = 8'h66; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 32'(busy), 1);
        check("sa_int", 32'(dpi.int_ctrl), 1);
        check("sa_thres", 32'(dpi.thres_length), 32'h66);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Reset during BIN_PULSE
        do_start(8'h99, 1'b1);
        tick(); tick();
        check("rm_in_pulse", 32'(dpi.bin_ctrl), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rm_int",  32'(dpi.int_ctrl), 0);
        check("rm_bin",  32'(dpi.bin_ctrl), 0);
        check("rm_thres", 32'(dpi.thres_length), 0);
        check("rm_busy", 32'(busy), 0);
        check("rm_done", 32'(done), 0);
        check("rm_error", 32'(error), 0);
        check("rm_led",  32'(state_led), 32'(LedIdle));
        tick();
        check("rm_stay_idle", 32'(busy), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
